// File: rtl/rk_timing_pkg.sv
// Rotational timing constants and FSM state encoding shared by the
// emulated 2315 cartridge sector/index generator.
package rk_timing_pkg;

  localparam int REV_US_DEF        = 40000;
  localparam int SECTORS_DEF       = 8;
  localparam int PULSE_US_DEF      = 165;
  localparam int INDEX_LEAD_US_DEF = 2500;

  localparam int POS_W  = 16;
  localparam int USEC_W = 13;
  localparam int SECT_W = 3;
  localparam int PCNT_W = 8;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_SYNC     = 2'd1,
    ST_ROTATING = 2'd2
  } rot_state_e;

endpackage

// File: rtl/pulse_stretcher.sv
// Fixed-width active-low bus pulse. Selection is sampled only on the leading
// edge; the width is counted in microsecond ticks.
module pulse_stretcher
  import rk_timing_pkg::*;
#(
  parameter int PULSE_US = PULSE_US_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_tick,
  input  logic i_start,
  input  logic i_sel,
  output logic o_pulse_l
);

  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_US);

  logic [PCNT_W-1:0] r_cnt;
  logic              r_pulse_l;

  // Load on a selected leading edge, then release the line after PULSE_US ticks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pulse_l <= 1'b1;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_pulse_l <= 1'b1;
    end else if (i_start && i_sel) begin
      r_cnt     <= PULSE_LOAD;
      r_pulse_l <= 1'b0;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt     <= r_cnt - PCNT_W'(1);
      r_pulse_l <= (r_cnt == PCNT_W'(1));
    end else begin
      r_cnt     <= r_cnt;
      r_pulse_l <= r_pulse_l;
    end
  end

  assign o_pulse_l = r_pulse_l;

endmodule

// File: rtl/sector_index_gen.sv
// Rotational position generator for the emulated 2315 cartridge: sector
// number, sector-start strobe and active-low sector/index bus pulses.
module sector_index_gen
  import rk_timing_pkg::*;
#(
  parameter int REV_US        = REV_US_DEF,
  parameter int SECTORS       = SECTORS_DEF,
  parameter int PULSE_US      = PULSE_US_DEF,
  parameter int INDEX_LEAD_US = INDEX_LEAD_US_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clkenbl_1usec,
  input  logic              Cart_Ready,
  input  logic              Selected,
  output logic              BUS_SECTOR_PULSE_L,
  output logic              BUS_INDEX_PULSE_L,
  output logic [SECT_W-1:0] sector_count,
  output logic              sector_start,
  output logic [USEC_W-1:0] us_in_sector
);

  localparam int                SECT_US   = REV_US / SECTORS;
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(REV_US - 1);
  localparam logic [POS_W-1:0]  POS_INDEX = POS_W'(REV_US - INDEX_LEAD_US);
  localparam logic [USEC_W-1:0] USEC_LAST = USEC_W'(SECT_US - 1);
  localparam logic [SECT_W-1:0] SECT_LAST = SECT_W'(SECTORS - 1);

  rot_state_e        r_state;
  logic [POS_W-1:0]  r_pos;
  logic [SECT_W-1:0] r_sector;
  logic [USEC_W-1:0] r_usec;
  logic              r_sector_start;

  logic [POS_W-1:0]  w_pos_next;
  logic              w_sync_tick;
  logic              w_rot_tick;
  logic              w_last_usec;
  logic              w_sector_go;
  logic              w_index_go;

  assign w_sync_tick = (r_state == ST_SYNC) && clkenbl_1usec && Cart_Ready;
  assign w_rot_tick  = (r_state == ST_ROTATING) && clkenbl_1usec && Cart_Ready;
  assign w_pos_next  = (r_pos == POS_LAST) ? '0 : r_pos + POS_W'(1);
  assign w_last_usec = (r_usec == USEC_LAST);
  assign w_sector_go = w_sync_tick || (w_rot_tick && w_last_usec);
  // The first tick out of SYNC is position 0, so an index at position 0 fires there.
  assign w_index_go  = (w_rot_tick && (w_pos_next == POS_INDEX)) ||
                       (w_sync_tick && (POS_INDEX == '0));

  // Rotation FSM with position, sector and strobe registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_STOPPED;
      r_pos          <= '0;
      r_sector       <= '0;
      r_usec         <= '0;
      r_sector_start <= 1'b0;
    end else if (!Cart_Ready) begin
      r_state        <= ST_STOPPED;
      r_pos          <= '0;
      r_sector       <= '0;
      r_usec         <= '0;
      r_sector_start <= 1'b0;
    end else begin
      r_sector_start <= 1'b0;
      case (r_state)
        ST_STOPPED: begin
          r_state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (clkenbl_1usec) begin
            r_state        <= ST_ROTATING;
            r_pos          <= '0;
            r_sector       <= '0;
            r_usec         <= '0;
            r_sector_start <= 1'b1;
          end else begin
            r_state <= ST_SYNC;
          end
        end
        ST_ROTATING: begin
          if (clkenbl_1usec) begin
            r_pos <= w_pos_next;
            if (w_last_usec) begin
              r_usec         <= '0;
              r_sector       <= (r_sector == SECT_LAST) ? '0 : r_sector + SECT_W'(1);
              r_sector_start <= 1'b1;
            end else begin
              r_usec <= r_usec + USEC_W'(1);
            end
          end else begin
            r_pos <= r_pos;
          end
        end
        default: begin
          r_state <= ST_STOPPED;
        end
      endcase
    end
  end

  pulse_stretcher #(.PULSE_US(PULSE_US)) u_sector_pulse (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!Cart_Ready),
    .i_tick    (clkenbl_1usec),
    .i_start   (w_sector_go),
    .i_sel     (Selected),
    .o_pulse_l (BUS_SECTOR_PULSE_L)
  );

  pulse_stretcher #(.PULSE_US(PULSE_US)) u_index_pulse (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!Cart_Ready),
    .i_tick    (clkenbl_1usec),
    .i_start   (w_index_go),
    .i_sel     (Selected),
    .o_pulse_l (BUS_INDEX_PULSE_L)
  );

  assign sector_count = r_sector;
  assign sector_start = r_sector_start;
  assign us_in_sector = r_usec;

endmodule

// File: tb/tb_sector_index_gen.sv
// Self-checking bench for sector_index_gen: vector table, timing measurements
// and a tick-count reference model compared every clock.
`timescale 1ns/1ps
module tb_sector_index_gen;

  localparam int REV  = 40000;
  localparam int NSEC = 8;
  localparam int SECT = 5000;
  localparam int PW   = 165;
  localparam int LEAD = 2500;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clkenbl_1usec = 1'b0;
  logic        Cart_Ready = 1'b0;
  logic        Selected = 1'b0;
  logic        BUS_SECTOR_PULSE_L;
  logic        BUS_INDEX_PULSE_L;
  logic [2:0]  sector_count;
  logic        sector_start;
  logic [12:0] us_in_sector;

  sector_index_gen dut (
    .clock              (clock),
    .reset              (reset),
    .clkenbl_1usec      (clkenbl_1usec),
    .Cart_Ready         (Cart_Ready),
    .Selected           (Selected),
    .BUS_SECTOR_PULSE_L (BUS_SECTOR_PULSE_L),
    .BUS_INDEX_PULSE_L  (BUS_INDEX_PULSE_L),
    .sector_count       (sector_count),
    .sector_start       (sector_start),
    .us_in_sector       (us_in_sector)
  );

  always #12.5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: microseconds since rotation start plus per-pulse edge records.
  bit m_armed, m_rot, m_start, m_sp_sel, m_ix_sel;
  int m_ticks, m_sp_edge, m_ix_edge;

  typedef struct {
    bit          rdy;
    bit          sel;
    bit          tick;
    logic [18:0] exp;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [18:0] mk(bit sp, bit ix, bit st, int cnt, int us);
    return {sp, ix, st, 3'(cnt), 13'(us)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {BUS_SECTOR_PULSE_L, BUS_INDEX_PULSE_L, sector_start, sector_count, us_in_sector};
  endfunction

  function automatic logic [18:0] model_vec();
    int pos;
    bit sp, ix;
    if (!m_rot) return mk(1'b1, 1'b1, 1'b0, 0, 0);
    pos = m_ticks % REV;
    sp  = !(m_sp_sel && ((m_ticks - m_sp_edge) < PW));
    ix  = !(m_ix_sel && ((m_ticks - m_ix_edge) < PW));
    return mk(sp, ix, m_start, pos / SECT, pos % SECT);
  endfunction

  task automatic model_update(bit tick, bit sel, bit rdy);
    int pos;
    m_start = 1'b0;
    if (!rdy) begin
      m_armed = 1'b0; m_rot = 1'b0; m_ticks = 0; m_sp_sel = 1'b0; m_ix_sel = 1'b0;
    end else if (!m_rot && !m_armed) begin
      m_armed = 1'b1;
    end else if (m_armed && tick) begin
      m_armed = 1'b0; m_rot = 1'b1; m_ticks = 0; m_start = 1'b1;
      m_sp_edge = 0; m_sp_sel = sel;
    end else if (m_rot && tick) begin
      m_ticks++;
      pos = m_ticks % REV;
      if (pos % SECT == 0) begin
        m_start = 1'b1; m_sp_edge = m_ticks; m_sp_sel = sel;
      end
      if (pos == REV - LEAD) begin
        m_ix_edge = m_ticks; m_ix_sel = sel;
      end
    end
  endtask

  task automatic check_vec(string name, logic [18:0] act, logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got sp=%b ix=%b st=%b cnt=%0d us=%0d required sp=%b ix=%b st=%b cnt=%0d us=%0d",
               name, $time, act[18], act[17], act[16], act[15:13], act[12:0],
               exp[18], exp[17], exp[16], exp[15:13], exp[12:0]);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d required %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic step(bit tick, bit sel, bit rdy);
    clkenbl_1usec = tick;
    Selected      = sel;
    Cart_Ready    = rdy;
    @(posedge clock);
    model_update(tick, sel, rdy);
    @(negedge clock);
    check_vec("model", dut_vec(), model_vec());
  endtask

  bit sp_prev, ix_prev, sel_v;
  int last_sfall, n_sfall, n_ixfall, n_strobe, ix_fall, pos_v;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 0, 0)};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, mk(1'b0, 1'b1, 1'b1, 0, 0)};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 0, 0)};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 0, 1)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b0, 0, 0)};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 0, 0)};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b1, 0, 0)};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 0, 1)};
    tbl[10] = '{1'b0, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 0, 0)};

    repeat (3) @(negedge clock);
    check_vec("reset", dut_vec(), mk(1'b1, 1'b1, 1'b0, 0, 0));
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].tick, tbl[i].sel, tbl[i].rdy);
      check_vec($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // Full revolution: Selected drops 50 us into sector 1's pulse, rises 50 us into sector 3's.
    step(1'b0, 1'b1, 1'b1);
    sp_prev = 1'b1; ix_prev = 1'b1; last_sfall = -1;
    n_sfall = 0; n_ixfall = 0; n_strobe = 0; ix_fall = -1;
    for (int i = 0; i <= REV + 1000; i++) begin
      sel_v = !((i >= 5050) && (i < 15050));
      step(1'b1, sel_v, 1'b1);
      if (i == 0) check_int("first_strobe", int'(sector_start), 1);
      if (sector_start) begin
        check_int("strobe_pos", i % SECT, 0);
        check_int("sector_seq", int'(sector_count), n_strobe % NSEC);
        n_strobe++;
      end
      if (sp_prev && !BUS_SECTOR_PULSE_L) begin
        if (last_sfall >= 20000) check_int("sector_period", i - last_sfall, SECT);
        last_sfall = i;
        n_sfall++;
      end
      if (!sp_prev && BUS_SECTOR_PULSE_L) check_int("sector_width", i - last_sfall, PW);
      if (ix_prev && !BUS_INDEX_PULSE_L) begin
        check_int("index_lead", i, REV - LEAD);
        ix_fall = i;
        n_ixfall++;
      end
      if (!ix_prev && BUS_INDEX_PULSE_L) check_int("index_width", i - ix_fall, PW);
      sp_prev = BUS_SECTOR_PULSE_L;
      ix_prev = BUS_INDEX_PULSE_L;
    end
    check_int("sector_pulse_count", n_sfall, 7);
    check_int("index_pulse_count", n_ixfall, 1);
    check_int("strobe_count", n_strobe, 9);

    // Deselected start, then random selection and tick gaps up to sector 5's pulse.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    pos_v = 0; sel_v = 1'b0; n_sfall = 0; n_strobe = 0; sp_prev = 1'b1; ix_prev = 1'b1;
    while (pos_v <= 5 * SECT + 50) begin
      if (pos_v >= 10100) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, sel_v, 1'b1);
        if (pos_v >= 5 * SECT - 100) sel_v = 1'b1;
        else if ($urandom_range(0, 63) == 0) sel_v = !sel_v;
      end
      step(1'b1, sel_v, 1'b1);
      if (pos_v < 10100) begin
        if (!BUS_SECTOR_PULSE_L || !BUS_INDEX_PULSE_L) n_sfall++;
        if (sector_start) n_strobe++;
      end
      pos_v++;
    end
    check_int("desel_bus_low_cycles", n_sfall, 0);
    check_int("desel_strobes", n_strobe, 3);
    check_int("sector5_low", int'(BUS_SECTOR_PULSE_L), 0);
    check_int("sector5_count", int'(sector_count), 5);

    step(1'b0, 1'b1, 1'b0);
    check_int("drop_bus", int'(BUS_SECTOR_PULSE_L), 1);
    check_int("drop_count", int'(sector_count), 0);
    check_int("drop_us", int'(us_in_sector), 0);

    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check_int("restart_strobe", int'(sector_start), 1);
    check_int("restart_count", int'(sector_count), 0);
    check_int("restart_pulse", int'(BUS_SECTOR_PULSE_L), 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);

    #3;
    reset = 1'b0;
    #1;
    check_int("async_reset_sector", int'(BUS_SECTOR_PULSE_L), 1);
    check_int("async_reset_count", int'(sector_count), 0);
    #50;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sector_index_gen.md
# sector_index_gen

Rotational timing generator for the emulated 2315 cartridge. It runs a microsecond position counter around one emulated revolution while the cartridge is loaded. From that position it derives the sector number, a sector-start strobe for the read/write data path, and the active-low sector and index pulses driven onto the drive bus. It sits directly downstream of `drive_select`, consuming its `Selected` output together with `Cart_Ready` and the shared `clkenbl_1usec` tick from the timing generator.

## Interface
Parameters:
- `REV_US`, 40000: revolution length in µs (1500 rpm).
- `SECTORS`, 8: sectors per revolution; must divide `REV_US`.
- `PULSE_US`, 165: width of each sector and index pulse in µs.
- `INDEX_LEAD_US`, 2500: index pulse leading edge precedes the sector-0 boundary by this many µs.

Ports:
- `clock`  in  1: system clock (40 MHz).
- `reset`  in  1: asynchronous, active-low reset.
- `clkenbl_1usec`  in  1: one-clock enable, once per µs.
- `Cart_Ready`  in  1: cartridge image loaded; rotation runs while high.
- `Selected`  in  1: drive selected, from `drive_select`.
- `BUS_SECTOR_PULSE_L`  out  1: sector pulse to bus, active low.
- `BUS_INDEX_PULSE_L`  out  1: index pulse to bus, active low.
- `sector_count`  out  3: current sector, 0..SECTORS-1.
- `sector_start`  out  1: one-clock strobe at each sector boundary (internal, ungated by `Selected`).
- `us_in_sector`  out  13: µs offset within the current sector.

## Operation
- FSM states: STOPPED, SYNC, ROTATING.
  - STOPPED → SYNC when `Cart_Ready`=1.
  - SYNC → ROTATING on the first `clkenbl_1usec`. That tick is position 0: sector 0 boundary, `sector_start` pulses.
  - ROTATING: the position counter (16 bit) increments on each `clkenbl_1usec` and wraps `REV_US`-1 → 0.
  - Any state → STOPPED when `Cart_Ready`=0. Counters clear and all pulses deassert immediately, with no pulse completion.
- Sector boundary occurs when position equals k·(`REV_US`/`SECTORS`). `sector_count` increments there and wraps 7→0 at position 0. `us_in_sector` clears to 0 at the boundary.
- Sector pulse begins at each boundary and lasts `PULSE_US` ticks.
- Index pulse begins at position `REV_US`-`INDEX_LEAD_US` and lasts `PULSE_US` ticks.
- Bus gating: `Selected` is sampled at each pulse's leading edge.
  - If 1, the pulse is driven for its full width even if `Selected` drops mid-pulse.
  - If 0, the pulse is suppressed entirely.
  - Selection rising mid-pulse does not start a truncated pulse.
- `sector_start`, `sector_count` and `us_in_sector` run regardless of `Selected`.

## Timing
- Reset values: state STOPPED, position 0, `sector_count`=0, `us_in_sector`=0, `sector_start`=0, `BUS_SECTOR_PULSE_L`=1, `BUS_INDEX_PULSE_L`=1.
- All outputs are registered. Changes appear one clock after the `clkenbl_1usec` cycle that causes them.
- Pulse low time is exactly `PULSE_US` µs, measured between enable ticks.
- `Cart_Ready` falling takes effect on the next clock, independent of `clkenbl_1usec`.
- Reset asserted mid-pulse releases the bus lines asynchronously.

## Structure
- Shared package (`rk_timing_pkg`): revolution, sector and pulse-width constants, and the FSM state encoding.
- One sub-module, `pulse_stretcher`, instantiated twice. It provides leading-edge capture of `Selected`, a `PULSE_US` µs down-counter, and an active-low registered output.

## Test plan
- Reset, then `Cart_Ready`=1 and `Selected`=1.
  - Expect: first `sector_start` on the first tick after SYNC.
  - Expect: sector pulses low for 165 µs every 5000 µs.
  - Expect: `sector_count` sequence 0..7,0.
- Same setup, checking index timing.
  - Expect: index low for 165 µs, with leading edge 37500 µs after the sector-0 boundary.
  - Expect: period of 40000 µs.
- `Selected`=0 throughout.
  - Expect: bus lines stay 1.
  - Expect: `sector_start` and `sector_count` still advance.
- Deassert `Selected` 50 µs into a sector pulse.
  - Expect: the pulse completes its 165 µs, and the next pulse is suppressed.
- Assert `Selected` 50 µs into a pulse.
  - Expect: no bus pulse until the next boundary.
- Drop `Cart_Ready` mid-pulse in sector 5.
  - Expect: the bus line goes 1 and `sector_count`=0 next clock.
  - On re-raise, expect rotation to restart at sector 0.
